div_sweep_sequencer: RTL and testbench

- Controller that reprograms the clock-divider terminal count so the output frequency sweeps through a configured range.
- Each step holds for a programmable number of divider output toggles.
- Sits between the control inputs and the divider instance: drives the divider's terminal-count value and a load strobe, and consumes the divider's per-toggle tick.
- Supports single up sweep, single down sweep, continuous ping-pong and repeating up sweep.

---
 rtl/div_sweep_sequencer.sv | 167 ++++++++++++++++
 tb/tb_div_sweep_sequencer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/div_sweep_sequencer.sv
// Frequency-sweep controller for a clock divider: steps the divider terminal count
// between two bounds, holding each value for a programmable number of divider toggles.
module div_sweep_sequencer #(
   parameter int          DIV_W   = 26,
   parameter int          DWELL_W = 8,
   parameter int unsigned RST_DIV = 59999999
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               abort,
   input  logic [1:0]         mode,
   input  logic [DIV_W-1:0]   div_start,
   input  logic [DIV_W-1:0]   div_end,
   input  logic [DIV_W-1:0]   div_step,
   input  logic [DWELL_W-1:0] dwell,
   input  logic               div_tick,
   output logic [DIV_W-1:0]   div_value,
   output logic               div_load,
   output logic               busy,
   output logic               done,
   output logic               cfg_err
);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DWELL, S_DONE} state_t;

   localparam logic [1:0] M_UP_ONCE  = 2'd0;
   localparam logic [1:0] M_DN_ONCE  = 2'd1;
   localparam logic [1:0] M_PINGPONG = 2'd2;
   localparam logic [1:0] M_UP_REP   = 2'd3;

   state_t               state, state_nxt;
   logic [DIV_W-1:0]     cur, cur_nxt;
   logic                 dir, dir_nxt;
   logic [DWELL_W-1:0]   cnt, cnt_nxt, cnt_inc;
   logic                 err_nxt;
   logic                 latch;
   logic                 cfg_bad;
   logic                 at_bound;
   logic [DIV_W-1:0]     dn_bound;

   logic [1:0]           mode_r;
   logic [DIV_W-1:0]     start_r, end_r, step_r;
   logic [DWELL_W-1:0]   dwell_r;

   // Sums are formed one bit wider so a step past the bound clamps instead of wrapping.
   function automatic logic [DIV_W-1:0] clamp_up(input logic [DIV_W-1:0] v,
                                                 input logic [DIV_W-1:0] s,
                                                 input logic [DIV_W-1:0] hi);
      logic [DIV_W:0] sum;
      sum = {1'b0, v} + {1'b0, s};
      if (sum > {1'b0, hi}) return hi;
      return sum[DIV_W-1:0];
   endfunction

   function automatic logic [DIV_W-1:0] clamp_dn(input logic [DIV_W-1:0] v,
                                                 input logic [DIV_W-1:0] s,
                                                 input logic [DIV_W-1:0] lo);
      logic [DIV_W:0] diff;
      diff = {1'b0, v} - {1'b0, s};
      if (diff[DIV_W] || (diff[DIV_W-1:0] < lo)) return lo;
      return diff[DIV_W-1:0];
   endfunction

   assign cfg_bad  = (mode == M_DN_ONCE) ? (div_start < div_end) : (div_start > div_end);
   // Down-once sweeps toward div_end; ping-pong turns around at div_start.
   assign dn_bound = (mode_r == M_DN_ONCE) ? end_r : start_r;
   assign at_bound = dir ? (cur == dn_bound) : (cur == end_r);
   assign cnt_inc  = cnt + 1'b1;

   always_comb begin
      state_nxt = state;
      cur_nxt   = cur;
      dir_nxt   = dir;
      cnt_nxt   = cnt;
      err_nxt   = 1'b0;
      latch     = 1'b0;
      case (state)
         S_IDLE: begin
            if (start && !abort) begin
               if (cfg_bad) begin
                  err_nxt = 1'b1;
               end else begin
                  latch     = 1'b1;
                  cur_nxt   = div_start;
                  dir_nxt   = (mode == M_DN_ONCE);
                  state_nxt = S_LOAD;
               end
            end
         end
         S_LOAD: begin
            cnt_nxt   = '0;
            state_nxt = S_DWELL;
         end
         S_DWELL: begin
            if (div_tick) begin
               if (cnt_inc != dwell_r) begin
                  cnt_nxt = cnt_inc;
               end else begin
                  state_nxt = S_LOAD;
                  if (!at_bound) begin
                     cur_nxt = dir ? clamp_dn(cur, step_r, dn_bound) : clamp_up(cur, step_r, end_r);
                  end else begin
                     case (mode_r)
                        M_UP_ONCE, M_DN_ONCE: state_nxt = S_DONE;
                        M_UP_REP: begin
                           cur_nxt = start_r;
                           dir_nxt = 1'b0;
                        end
                        M_PINGPONG: begin
                           // Turn around without repeating the endpoint; a degenerate range reloads in place.
                           if (start_r != end_r) begin
                              dir_nxt = !dir;
                              cur_nxt = dir ? clamp_up(cur, step_r, end_r) : clamp_dn(cur, step_r, start_r);
                           end
                        end
                        default: state_nxt = S_DONE;
                     endcase
                  end
               end
            end
         end
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
      if (abort) begin
         state_nxt = S_IDLE;
         err_nxt   = 1'b0;
         latch     = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         cur       <= '0;
         dir       <= 1'b0;
         cnt       <= '0;
         div_value <= DIV_W'(RST_DIV);
         div_load  <= 1'b0;
         cfg_err   <= 1'b0;
      end else begin
         state    <= state_nxt;
         cur      <= cur_nxt;
         dir      <= dir_nxt;
         cnt      <= cnt_nxt;
         cfg_err  <= err_nxt;
         div_load <= (state == S_LOAD) && !abort;
         if ((state == S_LOAD) && !abort) div_value <= cur;
      end
   end

   // Sweep configuration is held from start until the next IDLE; no reset needed.
   always_ff @(posedge clk) begin
      if (latch) begin
         mode_r  <= mode;
         start_r <= div_start;
         end_r   <= div_end;
         step_r  <= (div_step == '0) ? DIV_W'(1) : div_step;
         dwell_r <= (dwell == '0) ? DWELL_W'(1) : dwell;
      end
   end

   assign busy = (state == S_LOAD) || (state == S_DWELL);
   assign done = (state == S_DONE);

endmodule

// File: tb/tb_div_sweep_sequencer.sv
// Directed bench for div_sweep_sequencer: expected load values are queued at start
// and popped/compared whenever the controller strobes div_load.
module tb_div_sweep_sequencer;
   localparam int DIV_W   = 26;
   localparam int DWELL_W = 8;
   localparam logic [DIV_W-1:0] RSTV = 26'd59999999;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               start = 1'b0;
   logic               abort = 1'b0;
   logic [1:0]         mode = 2'd0;
   logic [DIV_W-1:0]   div_start = '0;
   logic [DIV_W-1:0]   div_end = '0;
   logic [DIV_W-1:0]   div_step = '0;
   logic [DWELL_W-1:0] dwell = '0;
   logic               div_tick = 1'b0;
   logic [DIV_W-1:0]   div_value;
   logic               div_load, busy, done, cfg_err;

   int total = 0;
   int bad = 0;
   int done_cnt = 0;
   int tick_period = 4;
   logic [DIV_W-1:0] sb[$];

   div_sweep_sequencer dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .mode(mode),
      .div_start(div_start), .div_end(div_end), .div_step(div_step), .dwell(dwell),
      .div_tick(div_tick), .div_value(div_value), .div_load(div_load),
      .busy(busy), .done(done), .cfg_err(cfg_err)
   );

   always #5 clk = ~clk;

   initial begin : tick_gen
      int tcnt;
      tcnt = 0;
      forever begin
         @(posedge clk);
         #1;
         if (tcnt >= tick_period - 1) begin
            div_tick = 1'b1;
            tcnt = 0;
         end else begin
            div_tick = 1'b0;
            tcnt++;
         end
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && div_load) begin
         if (sb.size() == 0) begin
            total++;
            bad++;
            $error("FAIL unexpected_load observed=%0d expected=none", div_value);
         end else begin
            chk("load_value", 64'(div_value), 64'(sb.pop_front()));
         end
      end
      if (rst_n && done) begin
         done_cnt++;
         chk("busy_with_done", 64'(busy), 64'd0);
      end
   end

   task automatic pulse_start();
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
   endtask

   task automatic setup(input logic [1:0] m, input int s, input int e, input int st, input int dw);
      mode = m;
      div_start = DIV_W'(s);
      div_end = DIV_W'(e);
      div_step = DIV_W'(st);
      dwell = DWELL_W'(dw);
   endtask

   task automatic wait_done(input string tag, input int target, input int budget);
      int n;
      n = 0;
      while (done_cnt < target && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk(tag, 64'(done_cnt), 64'(target));
      @(negedge clk);
      chk({tag, "_queue_empty"}, 64'(sb.size()), 64'd0);
   endtask

   initial begin
      int n;
      int base;
      // Reset values
      #12;
      chk("rst_div_value", 64'(div_value), 64'(RSTV));
      chk("rst_div_load", 64'(div_load), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_cfg_err", 64'(cfg_err), 64'd0);
      @(negedge clk) rst_n = 1'b1;

      // Rejected configuration
      setup(2'd0, 200, 100, 10, 2);
      pulse_start();
      @(negedge clk);
      chk("cfg_err_pulse", 64'(cfg_err), 64'd1);
      chk("cfg_err_busy", 64'(busy), 64'd0);
      chk("cfg_err_div_value", 64'(div_value), 64'(RSTV));
      @(negedge clk);
      chk("cfg_err_one_cycle", 64'(cfg_err), 64'd0);
      chk("cfg_err_state_idle", 64'(busy), 64'd0);

      // Start together with abort
      setup(2'd0, 100, 130, 10, 2);
      abort = 1'b1;
      pulse_start();
      repeat (3) @(negedge clk);
      chk("abort_start_busy", 64'(busy), 64'd0);
      abort = 1'b0;

      // Up-once, exact end
      tick_period = 4;
      sb.push_back(26'd100); sb.push_back(26'd110); sb.push_back(26'd120); sb.push_back(26'd130);
      pulse_start();
      @(negedge clk);
      chk("load_latency_busy", 64'(busy), 64'd1);
      @(negedge clk);
      chk("load_latency_strobe", 64'(div_load), 64'd1);
      wait_done("up_once_done", 1, 400);
      repeat (5) @(negedge clk);
      chk("up_once_single_done", 64'(done_cnt), 64'd1);
      chk("up_once_div_value_hold", 64'(div_value), 64'd130);

      // Up-once with clamp, plus start while busy
      setup(2'd0, 100, 125, 10, 2);
      sb.push_back(26'd100); sb.push_back(26'd110); sb.push_back(26'd120); sb.push_back(26'd125);
      pulse_start();
      repeat (6) @(negedge clk);
      setup(2'd0, 200, 100, 10, 2);
      pulse_start();
      @(negedge clk);
      chk("busy_start_no_err", 64'(cfg_err), 64'd0);
      chk("busy_start_still_busy", 64'(busy), 64'd1);
      wait_done("clamp_done", 2, 400);

      // Down-once, step 0 and dwell 0 treated as 1
      tick_period = 2;
      setup(2'd1, 50, 20, 0, 0);
      for (int v = 50; v >= 20; v--) sb.push_back(DIV_W'(v));
      pulse_start();
      wait_done("down_done", 3, 1000);

      // Ping-pong, then abort mid-dwell
      tick_period = 3;
      setup(2'd2, 10, 14, 2, 1);
      base = done_cnt;
      sb.push_back(26'd10); sb.push_back(26'd12); sb.push_back(26'd14); sb.push_back(26'd12);
      sb.push_back(26'd10); sb.push_back(26'd12); sb.push_back(26'd14);
      pulse_start();
      n = 0;
      while (sb.size() != 0 && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk("pingpong_all_loads", 64'(sb.size()), 64'd0);
      abort = 1'b1;
      @(posedge clk); #1 abort = 1'b0;
      @(negedge clk);
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_div_value", 64'(div_value), 64'd14);
      repeat (20) @(negedge clk);
      chk("pingpong_no_done", 64'(done_cnt), 64'(base));
      chk("abort_stays_idle", 64'(busy), 64'd0);

      // Asynchronous reset mid-sweep
      tick_period = 4;
      setup(2'd0, 100, 130, 10, 2);
      sb.push_back(26'd100); sb.push_back(26'd110);
      pulse_start();
      n = 0;
      while (sb.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_div_value", 64'(div_value), 64'(RSTV));
      chk("async_rst_busy", 64'(busy), 64'd0);
      sb.delete();
      @(negedge clk) rst_n = 1'b1;
      base = done_cnt;
      sb.push_back(26'd100); sb.push_back(26'd110); sb.push_back(26'd120); sb.push_back(26'd130);
      pulse_start();
      wait_done("after_reset_done", base + 1, 400);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end
endmodule
